// File: rtl/sched_pkg.sv
// Shared definitions for the process scheduler: FSM encoding, default
// parameter values and a small sizing helper.
package sched_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SAVE = 2'd1,
    ST_LOAD = 2'd2,
    ST_IDLE = 2'd3
  } sched_state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_TRACKS     = 2;
  localparam int DEFAULT_QUANTUM    = 16;
  localparam int DEFAULT_PC_STRIDE  = 256;

  // Width of an internal process index (at least one bit).
  function automatic int id_width(input int tracks);
    return (tracks > 1) ? $clog2(tracks) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin next-process search. Candidates are current+1, current+2, ...
// wrapping modulo TRACKS, with current itself tried last. The nearest
// non-halted candidate wins; found=0 when every process is halted.
module rr_picker #(
  parameter int TRACKS = 2,
  parameter int ID_W   = 1
) (
  input  logic [TRACKS-1:0] halted,
  input  logic [ID_W-1:0]   current,
  output logic [ID_W-1:0]   next_id,
  output logic              found
);

  logic [ID_W-1:0] cand [TRACKS];

  genvar gi;
  generate
    for (gi = 0; gi < TRACKS; gi++) begin : g_cand
      localparam int OFFSET = gi + 1;
      assign cand[gi] = ID_W'((int'(current) + OFFSET) % TRACKS);
    end
  endgenerate

  // Scan from farthest to nearest so the nearest free candidate overrides.
  always_comb begin
    next_id = current;
    found   = 1'b0;
    for (int k = TRACKS - 1; k >= 0; k--) begin
      if (!halted[cand[k]]) begin
        next_id = cand[k];
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// Time-slicing scheduler for a multi-context core. Runs one process for a
// quantum of retired instructions (or until it halts), then spends one cycle
// saving its PC and one cycle picking and loading the next process.
module process_scheduler
  import sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int TRACKS     = DEFAULT_TRACKS,
  parameter int QUANTUM    = DEFAULT_QUANTUM,
  parameter int PC_STRIDE  = DEFAULT_PC_STRIDE
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  instr_retired,
  input  logic                  halt_req,
  input  logic                  restart,
  input  logic [DATA_WIDTH-1:0] pc_in,
  output logic [DATA_WIDTH-1:0] pId,
  output logic [DATA_WIDTH-1:0] writepId,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic                  pc_load,
  output logic                  stall,
  output logic                  all_halted
);

  localparam int         ID_W  = id_width(TRACKS);
  localparam logic [7:0] QLAST = 8'(QUANTUM - 1);

  sched_state_e          state_reg;
  logic [ID_W-1:0]       pid_reg;
  logic [DATA_WIDTH-1:0] pc_out_reg;
  logic                  pc_load_reg;
  logic [7:0]            qcount_reg;
  logic                  halt_pend_reg;

  logic [DATA_WIDTH-1:0] pc_table [TRACKS];
  logic [TRACKS-1:0]     halted;

  logic [ID_W-1:0]       pick_id;
  logic                  pick_found;

  rr_picker #(
    .TRACKS (TRACKS),
    .ID_W   (ID_W)
  ) u_picker (
    .halted  (halted),
    .current (pid_reg),
    .next_id (pick_id),
    .found   (pick_found)
  );

  genvar gi;
  generate
    for (gi = 0; gi < TRACKS; gi++) begin : g_track
      localparam logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(gi * PC_STRIDE);
      logic [DATA_WIDTH-1:0] entry_reg;
      logic                  halted_reg;
      logic                  sel;

      assign sel          = (pid_reg == ID_W'(gi));
      assign pc_table[gi] = entry_reg;
      assign halted[gi]   = halted_reg;

      // Per-process saved PC and halted flag; written only in SAVE, flags cleared by restart in IDLE.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          entry_reg  <= RESET_PC;
          halted_reg <= 1'b0;
        end else if (enable) begin
          if (state_reg == ST_SAVE && sel) begin
            entry_reg <= pc_in;
            if (halt_pend_reg) halted_reg <= 1'b1;
          end else if (state_reg == ST_IDLE && restart) begin
            halted_reg <= 1'b0;
          end
        end
      end
    end
  endgenerate

  // Scheduler FSM with registered process id, PC and load pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_RUN;
      pid_reg       <= '0;
      pc_out_reg    <= '0;
      pc_load_reg   <= 1'b0;
      qcount_reg    <= 8'd0;
      halt_pend_reg <= 1'b0;
    end else if (!enable) begin
      pc_load_reg <= 1'b0;
    end else begin
      pc_load_reg <= 1'b0;
      case (state_reg)
        ST_RUN: begin
          if (instr_retired) begin
            // Halt wins over expiry: halt_pend records why the slice ended.
            if (halt_req || qcount_reg == QLAST) begin
              halt_pend_reg <= halt_req;
              state_reg     <= ST_SAVE;
            end else begin
              qcount_reg <= qcount_reg + 8'd1;
            end
          end
        end
        ST_SAVE: begin
          qcount_reg <= 8'd0;
          state_reg  <= ST_LOAD;
        end
        ST_LOAD: begin
          halt_pend_reg <= 1'b0;
          if (pick_found) begin
            pid_reg     <= pick_id;
            pc_out_reg  <= pc_table[pick_id];
            pc_load_reg <= 1'b1;
            state_reg   <= ST_RUN;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (restart) begin
            pid_reg     <= '0;
            pc_out_reg  <= pc_table[0];
            pc_load_reg <= 1'b1;
            state_reg   <= ST_RUN;
          end
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  assign pId        = DATA_WIDTH'(pid_reg);
  assign writepId   = DATA_WIDTH'(pid_reg);
  assign pc_out     = pc_out_reg;
  assign pc_load    = pc_load_reg & enable;
  assign stall      = (state_reg != ST_RUN);
  assign all_halted = (state_reg == ST_IDLE);

endmodule

// File: tb/tb_process_scheduler.sv
// Directed bench for process_scheduler: a 2-process instance exercises
// switching, halting, idle/restart, enable freeze and reset mid-switch; a
// 4-process instance exercises round-robin skipping of halted processes.
module tb_process_scheduler;
  import sched_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        restart;
  logic [31:0] pc_in;
  logic        ir2, hr2, ir4, hr4;

  logic [31:0] pid2, wpid2, pcout2;
  logic        pcload2, stall2, allh2;
  logic [31:0] pid4, wpid4, pcout4;
  logic        pcload4, stall4, allh4;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  process_scheduler #(
    .DATA_WIDTH (32),
    .TRACKS     (2),
    .QUANTUM    (DEFAULT_QUANTUM),
    .PC_STRIDE  (DEFAULT_PC_STRIDE)
  ) dut2 (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .instr_retired (ir2),
    .halt_req      (hr2),
    .restart       (restart),
    .pc_in         (pc_in),
    .pId           (pid2),
    .writepId      (wpid2),
    .pc_out        (pcout2),
    .pc_load       (pcload2),
    .stall         (stall2),
    .all_halted    (allh2)
  );

  process_scheduler #(
    .DATA_WIDTH (32),
    .TRACKS     (4),
    .QUANTUM    (4),
    .PC_STRIDE  (DEFAULT_PC_STRIDE)
  ) dut4 (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .instr_retired (ir4),
    .halt_req      (hr4),
    .restart       (restart),
    .pc_in         (pc_in),
    .pId           (pid4),
    .writepId      (wpid4),
    .pc_out        (pcout4),
    .pc_load       (pcload4),
    .stall         (stall4),
    .all_halted    (allh4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[%0t] %s ok: 0x%0h", $time, tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Retire n instructions on the selected instance; halt_req on the last one if asked.
  task automatic retire(input int sel, input int n, input bit halt_last);
    for (int i = 0; i < n; i++) begin
      if (sel == 2) begin
        ir2 = 1'b1;
        hr2 = halt_last && (i == n - 1);
      end else begin
        ir4 = 1'b1;
        hr4 = halt_last && (i == n - 1);
      end
      tick();
    end
    ir2 = 1'b0; hr2 = 1'b0; ir4 = 1'b0; hr4 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b1; restart = 1'b0; pc_in = 32'h0;
    ir2 = 1'b0; hr2 = 1'b0; ir4 = 1'b0; hr4 = 1'b0;
    repeat (2) tick();

    // Reset values
    check("rst_pid", pid2, 0);
    check("rst_wpid", wpid2, 0);
    check("rst_pcout", pcout2, 0);
    check("rst_pcload", pcload2, 0);
    check("rst_stall", stall2, 0);
    check("rst_allh", allh2, 0);
    reset_n = 1'b1;

    // Quantum expiry: SAVE after 16th retire, load of process 1 two cycles later
    retire(2, 15, 1'b0);
    check("q15_nostall", stall2, 0);
    retire(2, 1, 1'b0);
    check("q16_save_stall", stall2, 1);
    check("q16_no_load", pcload2, 0);
    pc_in = 32'h40;
    tick();
    check("load_stall", stall2, 1);
    tick();
    check("sw1_pcload", pcload2, 1);
    check("sw1_pid", pid2, 1);
    check("sw1_wpid", wpid2, 1);
    check("sw1_pcout", pcout2, 256);
    check("sw1_stall", stall2, 0);
    tick();
    check("sw1_pulse_end", pcload2, 0);

    // Process 1 halts at 0x120 -> back to process 0 at its saved PC
    pc_in = 32'h120;
    retire(2, 1, 1'b1);
    tick(); tick();
    check("halt1_pid", pid2, 0);
    check("halt1_pcout", pcout2, 32'h40);
    check("halt1_pcload", pcload2, 1);

    // Only process 0 alive: expiry re-selects it with its saved PC
    retire(2, 16, 1'b0);
    pc_in = 32'h55;
    tick(); tick();
    check("solo_pcload", pcload2, 1);
    check("solo_pid", pid2, 0);
    check("solo_pcout", pcout2, 32'h55);

    // Halt coinciding with 16th retire -> halted, all processes halted -> IDLE
    pc_in = 32'h77;
    retire(2, 16, 1'b1);
    tick(); tick();
    check("idle_allh", allh2, 1);
    check("idle_stall", stall2, 1);
    check("idle_no_load", pcload2, 0);
    tick();
    check("idle_hold", allh2, 1);

    // Restart from IDLE
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_pcload", pcload2, 1);
    check("restart_pid", pid2, 0);
    check("restart_pcout", pcout2, 32'h77);
    check("restart_allh", allh2, 0);

    // Restart ignored in RUN
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_run_ignored", pcload2, 0);
    check("restart_run_stall", stall2, 0);

    // Enable low during SAVE freezes the switch
    retire(2, 16, 1'b0);
    pc_in = 32'h99;
    enable = 1'b0;
    repeat (3) tick();
    check("frz_stall", stall2, 1);
    check("frz_no_load", pcload2, 0);
    enable = 1'b1;
    tick();
    check("frz_load_stall", stall2, 1);
    check("frz_not_loaded", pcload2, 0);
    tick();
    check("frz_pcload", pcload2, 1);
    check("frz_pid", pid2, 1);
    check("frz_pcout", pcout2, 32'h120);

    // Reset asserted in LOAD: async reset values, table restored
    pc_in = 32'hABC;
    retire(2, 16, 1'b0);
    tick();
    check("pre_rst_in_load", stall2, 1);
    reset_n = 1'b0;
    #2;
    check("arst_pid", pid2, 0);
    check("arst_wpid", wpid2, 0);
    check("arst_pcout", pcout2, 0);
    check("arst_pcload", pcload2, 0);
    check("arst_stall", stall2, 0);
    check("arst_allh", allh2, 0);
    tick();
    reset_n = 1'b1;
    retire(2, 16, 1'b0);
    tick(); tick();
    check("arst_tbl_pid", pid2, 1);
    check("arst_tbl_pc1", pcout2, 256);

    // Four processes: build halted mask 0b1010 then check round robin from 0
    pc_in = 32'h10;
    retire(4, 4, 1'b0);
    tick(); tick();
    check("t4_sw_pid1", pid4, 1);
    check("t4_sw_pc1", pcout4, 256);
    retire(4, 1, 1'b1);
    tick(); tick();
    check("t4_sw_pid2", pid4, 2);
    check("t4_sw_pc2", pcout4, 512);
    retire(4, 4, 1'b0);
    tick(); tick();
    check("t4_sw_pid3", pid4, 3);
    check("t4_sw_pc3", pcout4, 768);
    retire(4, 1, 1'b1);
    tick(); tick();
    check("t4_wrap_pid0", pid4, 0);
    check("t4_wrap_pc0", pcout4, 32'h10);
    retire(4, 4, 1'b0);
    pc_in = 32'h20;
    tick(); tick();
    check("t4_skip_pid2", pid4, 2);
    check("t4_skip_pc2", pcout4, 32'h10);
    retire(4, 4, 1'b0);
    pc_in = 32'h30;
    tick(); tick();
    check("t4_skip_pid0", pid4, 0);
    check("t4_skip_pc0", pcout4, 32'h20);
    check("t4_wpid", wpid4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
